// File: rtl/maxpool_controller.sv
// Max-pooling batch controller: clears the FIFOs, fills windows, then READ/POOL per window.
// Optional POOL watchdog: define MAXPOOL_CTRL_TIMEOUT_EN.
module maxpool_controller #(
  parameter int array_size = 9,
  parameter int cnt_width  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [cnt_width-1:0]    num_win,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*array_size-1:0] full,
  input  logic [4*array_size-1:0] empty,
  input  logic [array_size-1:0]   mp_done,
  output logic [4*array_size-1:0] sel,
  output logic [array_size-1:0]   r_en,
  output logic [array_size-1:0]   enable,
  output logic                    clear,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    done,
  output logic                    error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_POOL   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [1:0]           q_q, q_d;
  logic [cnt_width-1:0] win_q, win_d;
  logic [cnt_width-1:0] rem_q, rem_d;
  logic                 error_q, error_d;
  logic                 done_q, done_d;
  logic                 ov_q, ov_d;
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
  logic [7:0]           wd_q, wd_d;
`endif

  logic                 fill_ok;
  logic                 accept;
  logic [3:0]           q_hot;
  logic [cnt_width-1:0] win_inc;
  logic [cnt_width-1:0] rem_dec;
  logic                 pool_hold;

  // Beat acceptance and the per-lane quadrant one-hot
  always_comb begin
    fill_ok = (state_q == S_FILL) && !(|full);
    accept  = fill_ok && in_valid;
    q_hot   = 4'b0001 << q_q;
    win_inc = win_q + 1'b1;
    rem_dec = rem_q - 1'b1;
    // enable stays high until the lanes report done; the out_valid
    // cycle that follows is spent with the lanes idle
    pool_hold = (state_q == S_POOL) && !ov_q;
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    win_d   = win_q;
    rem_d   = rem_q;
    error_d = error_q;
    ov_d    = 1'b0;
    done_d  = (state_q == S_FINISH);
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          rem_d   = num_win;
          win_d   = '0;
          q_d     = 2'd0;
          if (num_win == '0)
            state_d = S_FINISH;
          else
            state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_FILL;
      end
      S_FILL: begin
        if (accept) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) begin
            win_d = win_inc;
            if (win_inc == rem_q)
              state_d = S_READ;
          end
        end
      end
      S_READ: begin
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
        wd_d = 8'd0;
`endif
        if (|empty) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_POOL;
        end
      end
      S_POOL: begin
        if (ov_q) begin
          rem_d = rem_dec;
          if (rem_dec != '0)
            state_d = S_READ;
          else
            state_d = S_FINISH;
        end else if (&mp_done) begin
          ov_d = 1'b1;
`ifdef MAXPOOL_CTRL_TIMEOUT_EN
        end else if (wd_q == 8'd254) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + 8'd1;
`endif
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= 2'd0;
      win_q   <= '0;
      rem_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      error_q <= error_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
    end
  end

`ifdef MAXPOOL_CTRL_TIMEOUT_EN
  // POOL watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_q <= 8'd0;
    else
      wd_q <= wd_d;
  end
`endif

  // Outputs decoded from state; states are exclusive so sel/r_en/enable never overlap
  always_comb begin
    in_ready  = fill_ok;
    sel       = accept ? {array_size{q_hot}} : '0;
    r_en      = {array_size{state_q == S_READ}};
    enable    = {array_size{pool_hold}};
    clear     = (state_q == S_CLEAR);
    busy      = (state_q != S_IDLE);
    out_valid = ov_q;
    done      = done_q;
    error     = error_q;
  end

endmodule
